// File: rtl/pooling_input_interface.sv
// Pairs consecutive conv rows of each feature map into 2x2 pooling row-pairs.
// One top row is held per feature until its bottom row arrives.
module pooling_input_interface #(
    parameter int DATA_WIDTH        = 32,
    parameter int ROW_SIZE          = 6,
    parameter int TOTAL_FEATURE     = 6,
    parameter int FEATURE_IDX_WIDTH = 3,
    parameter int IN_ROWS           = 12,
    parameter int PAIR_IDX_WIDTH    = 3
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               clear,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [FEATURE_IDX_WIDTH-1:0]       in_feature_idx,
    input  logic [ROW_SIZE*DATA_WIDTH-1:0]     in_data,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [FEATURE_IDX_WIDTH-1:0]       out_feature_idx,
    output logic [PAIR_IDX_WIDTH-1:0]          out_pair_idx,
    output logic [ROW_SIZE*DATA_WIDTH-1:0]     out_row_top,
    output logic [ROW_SIZE*DATA_WIDTH-1:0]     out_row_bot,
    output logic                               err_idx
);
    localparam int ROW_W = ROW_SIZE * DATA_WIDTH;
    localparam int PAIRS = IN_ROWS / 2;
    localparam logic [PAIR_IDX_WIDTH-1:0] LAST_PAIR = PAIR_IDX_WIDTH'(PAIRS - 1);

    logic [ROW_W-1:0]             slot_q [TOTAL_FEATURE];
    logic [TOTAL_FEATURE-1:0]     half_q;
    logic [PAIR_IDX_WIDTH-1:0]    cnt_q  [TOTAL_FEATURE];

    logic                         out_valid_q;
    logic [FEATURE_IDX_WIDTH-1:0] out_feat_q;
    logic [PAIR_IDX_WIDTH-1:0]    out_pair_q;
    logic [ROW_W-1:0]             out_top_q;
    logic [ROW_W-1:0]             out_bot_q;
    logic                         err_q;

    logic                         accept;
    logic                         in_range;
    logic                         complete;
    logic [TOTAL_FEATURE-1:0]     hit;
    logic [ROW_W-1:0]             sel_slot;
    logic [PAIR_IDX_WIDTH-1:0]    sel_cnt;

    assign in_ready = !clear && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;
    assign in_range = {1'b0, in_feature_idx}
                    < (FEATURE_IDX_WIDTH+1)'(TOTAL_FEATURE);

    // Out-of-range indices match no feature, so they never touch storage.
    always_comb begin
        hit      = '0;
        sel_slot = '0;
        sel_cnt  = '0;
        for (int f = 0; f < TOTAL_FEATURE; f++) begin
            if (in_feature_idx == FEATURE_IDX_WIDTH'(f)) begin
                hit[f]   = accept;
                sel_slot = slot_q[f];
                sel_cnt  = cnt_q[f];
            end
        end
    end

    assign complete = |(hit & half_q);

    always_ff @(posedge clk) begin
        for (int f = 0; f < TOTAL_FEATURE; f++) begin
            if (hit[f] && !half_q[f]) begin
                slot_q[f] <= in_data;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            half_q      <= '0;
            out_valid_q <= 1'b0;
            out_feat_q  <= '0;
            out_pair_q  <= '0;
            out_top_q   <= '0;
            out_bot_q   <= '0;
            err_q       <= 1'b0;
            for (int f = 0; f < TOTAL_FEATURE; f++) begin
                cnt_q[f] <= '0;
            end
        end else if (clear) begin
            half_q      <= '0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
            for (int f = 0; f < TOTAL_FEATURE; f++) begin
                cnt_q[f] <= '0;
            end
        end else begin
            if (accept && !in_range) begin
                err_q <= 1'b1;
            end
            for (int f = 0; f < TOTAL_FEATURE; f++) begin
                if (hit[f]) begin
                    half_q[f] <= !half_q[f];
                    if (half_q[f]) begin
                        cnt_q[f] <= (cnt_q[f] == LAST_PAIR) ? '0
                                  : cnt_q[f] + 1'b1;
                    end
                end
            end
            // A completing pair reloads even while the old one transfers.
            if (complete) begin
                out_valid_q <= 1'b1;
                out_feat_q  <= in_feature_idx;
                out_pair_q  <= sel_cnt;
                out_top_q   <= sel_slot;
                out_bot_q   <= in_data;
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_valid       = out_valid_q;
    assign out_feature_idx = out_feat_q;
    assign out_pair_idx    = out_pair_q;
    assign out_row_top     = out_top_q;
    assign out_row_bot     = out_bot_q;
    assign err_idx         = err_q;

endmodule

// File: tb/tb_pooling_input_interface.sv
// Randomized bench for pooling_input_interface against a per-feature
// row-pairing reference model.
module tb_pooling_input_interface;
    localparam int DW = 32, RS = 6, TF = 6, FW = 3, IR = 12, PW = 3;
    localparam int RW = DW * RS;
    localparam int PAIRS = IR / 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          clear = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [FW-1:0] in_feature_idx = '0;
    logic [RW-1:0] in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [FW-1:0] out_feature_idx;
    logic [PW-1:0] out_pair_idx;
    logic [RW-1:0] out_row_top;
    logic [RW-1:0] out_row_bot;
    logic          err_idx;

    pooling_input_interface #(
        .DATA_WIDTH(DW), .ROW_SIZE(RS), .TOTAL_FEATURE(TF),
        .FEATURE_IDX_WIDTH(FW), .IN_ROWS(IR), .PAIR_IDX_WIDTH(PW)
    ) dut (
        .clk(clk), .rst(rst), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_feature_idx(in_feature_idx), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_feature_idx(out_feature_idx), .out_pair_idx(out_pair_idx),
        .out_row_top(out_row_top), .out_row_bot(out_row_bot),
        .err_idx(err_idx)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model state
    bit            m_valid;
    int            m_feat, m_pair;
    logic [RW-1:0] m_top, m_bot;
    bit            m_err;
    bit            m_half [TF];
    logic [RW-1:0] m_slot [TF];
    int            m_cnt  [TF];

    task automatic check(input string tag, input logic [RW-1:0] got,
                         input logic [RW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [RW-1:0] mkrow(input int base);
        logic [RW-1:0] r;
        for (int w = 0; w < RS; w++) r[w*DW +: DW] = DW'(base + w);
        return r;
    endfunction

    function automatic logic [RW-1:0] rndrow();
        logic [RW-1:0] r;
        for (int w = 0; w < RS; w++) r[w*DW +: DW] = $urandom;
        return r;
    endfunction

    task automatic model_reset();
        m_valid = 0; m_feat = 0; m_pair = 0;
        m_top = '0; m_bot = '0; m_err = 0;
        for (int f = 0; f < TF; f++) begin
            m_half[f] = 0; m_cnt[f] = 0;
        end
    endtask

    task automatic cyc(input bit v, input int f, input logic [RW-1:0] d,
                       input bit ordy, input bit clr);
        bit rdy, newp;
        @(negedge clk);
        in_valid = v; in_feature_idx = FW'(f); in_data = d;
        out_ready = ordy; clear = clr;
        #1;
        rdy = !clr && (!m_valid || ordy);
        check("in_ready", RW'(in_ready), RW'(rdy));
        newp = 0;
        if (clr) begin
            m_valid = 0; m_err = 0;
            for (int k = 0; k < TF; k++) begin
                m_half[k] = 0; m_cnt[k] = 0;
            end
        end else begin
            if (v && rdy) begin
                if (f >= TF) m_err = 1;
                else if (!m_half[f]) begin
                    m_slot[f] = d; m_half[f] = 1;
                end else begin
                    m_top = m_slot[f]; m_bot = d;
                    m_feat = f; m_pair = m_cnt[f];
                    m_cnt[f] = (m_cnt[f] + 1) % PAIRS;
                    m_half[f] = 0; newp = 1;
                end
            end
            if (newp) m_valid = 1;
            else if (m_valid && ordy) m_valid = 0;
        end
        @(posedge clk); #1;
        check("out_valid", RW'(out_valid), RW'(m_valid));
        check("err_idx", RW'(err_idx), RW'(m_err));
        if (m_valid) begin
            check("out_feature_idx", RW'(out_feature_idx), RW'(m_feat));
            check("out_pair_idx", RW'(out_pair_idx), RW'(m_pair));
            check("out_row_top", out_row_top, m_top);
            check("out_row_bot", out_row_bot, m_bot);
        end
    endtask

    task automatic idle();
        cyc(0, 0, '0, 1, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1; in_valid = 0; clear = 0; out_ready = 1;
        model_reset();
        #1;
        check("rst_out_valid", RW'(out_valid), '0);
        @(negedge clk);
        check("rst_feat", RW'(out_feature_idx), '0);
        check("rst_pair", RW'(out_pair_idx), '0);
        check("rst_top", out_row_top, '0);
        check("rst_bot", out_row_bot, '0);
        check("rst_err", RW'(err_idx), '0);
        rst = 0;
    endtask

    logic [RW-1:0] rA, rB;
    int            fr;

    initial begin
        do_reset();

        // Basic pair on feature 2
        cyc(1, 2, mkrow(1), 1, 0);
        cyc(1, 2, mkrow(11), 1, 0);
        check("basic_top", out_row_top, mkrow(1));
        check("basic_bot", out_row_bot, mkrow(11));
        check("basic_feat", RW'(out_feature_idx), RW'(2));
        idle();

        // Interleaved features 0 and 1
        cyc(1, 0, mkrow(100), 1, 0);
        cyc(1, 1, mkrow(200), 1, 0);
        cyc(1, 0, mkrow(110), 1, 0);
        check("ilv_f0_top", out_row_top, mkrow(100));
        cyc(1, 1, mkrow(210), 1, 0);
        check("ilv_f1_bot", out_row_bot, mkrow(210));
        idle();

        // Backpressure, then release with a completing row
        cyc(1, 4, mkrow(400), 1, 0);
        cyc(1, 3, mkrow(300), 1, 0);
        cyc(1, 3, mkrow(310), 0, 0);
        rA = out_row_top;
        for (int i = 0; i < 5; i++) cyc(1, 4, mkrow(410), 0, 0);
        check("bp_stable_top", out_row_top, mkrow(300));
        cyc(1, 4, mkrow(410), 1, 0);
        check("bp_next_feat", RW'(out_feature_idx), RW'(4));
        idle();

        // Pair index wrap on feature 0 from a clean start
        cyc(0, 0, '0, 1, 1);
        for (int i = 0; i < 2 * PAIRS + 2; i++) cyc(1, 0, mkrow(1000 + i), 1, 0);
        check("wrap_pair", RW'(out_pair_idx), '0);
        idle();

        // Bad feature index, sticky error, then clear
        cyc(1, 7, mkrow(7), 1, 0);
        cyc(1, 6, mkrow(6), 1, 0);
        idle(); idle();
        check("err_sticky", RW'(err_idx), RW'(1));
        cyc(0, 0, '0, 1, 1);

        // Clear mid-operation discards a held top row
        cyc(1, 3, mkrow(50), 1, 0);
        cyc(0, 0, '0, 1, 1);
        cyc(1, 3, mkrow(60), 1, 0);
        idle();
        cyc(1, 3, mkrow(70), 1, 0);
        check("clr_top", out_row_top, mkrow(60));

        // Reset mid-operation likewise
        cyc(1, 5, mkrow(80), 1, 0);
        do_reset();
        cyc(1, 5, mkrow(90), 1, 0);
        cyc(1, 5, mkrow(95), 1, 0);
        check("rst_mid_top", out_row_top, mkrow(90));

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            fr = ($urandom_range(0, 24) == 0) ? $urandom_range(TF, 7)
                                              : $urandom_range(0, TF - 1);
            cyc($urandom_range(0, 3) != 0, fr, rndrow(),
                $urandom_range(0, 3) != 0, $urandom_range(0, 199) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
